// File: rtl/pipe_pkg.sv
// Shared types and default widths for the flow-controlled pipeline stage.
// The state encoding maps directly onto the number of entries the stage holds.
package pipe_pkg;

  localparam int PIPE_CTRL_W = 12;
  localparam int PIPE_DATA_W = 165;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  function automatic logic [1:0] state_count(input skid_state_t s);
    case (s)
      BUSY:    return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// One stored entry (control + data) with load enable and independent clears.
// Clears take priority over load; reset zeroes everything.
module pipe_payload_reg #(
  parameter int CTRL_W = 12,
  parameter int DATA_W = 165
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clr_ctrl,
  input  logic              clr_data,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [DATA_W-1:0] data_d,
  output logic [CTRL_W-1:0] ctrl_q,
  output logic [DATA_W-1:0] data_q
);

  // NOTE: non-blocking assignments in clocked blocks so every register samples
  // pre-edge values; the wide data word is reset too, so stale payload never
  // leaks out of reset even though it is not gated by valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      if (clr_ctrl)  ctrl_q <= '0;
      else if (load) ctrl_q <= ctrl_d;
      if (clr_data)  data_q <= '0;
      else if (load) data_q <= data_d;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Generic valid/ready pipeline stage with a two-entry skid buffer and flush.
// Main entry drives the outputs; the skid entry absorbs one stall cycle.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int CTRL_W              = PIPE_CTRL_W,
  parameter int DATA_W              = PIPE_DATA_W,
  parameter bit CLEAR_DATA_ON_FLUSH = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        count_o
);

  skid_state_t       state;
  logic              in_fire;
  logic              out_fire;
  logic              main_load;
  logic              skid_load;
  logic              main_from_skid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              clr_data;

  assign out_valid_o = (state != EMPTY);
  assign count_o     = state_count(state);
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;
  assign clr_data    = flush_i & CLEAR_DATA_ON_FLUSH;

  // Ready is a flop mirroring "not FULL", so out_ready_i never reaches in_ready_o.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      in_ready_o <= 1'b1;
    end else if (flush_i) begin
      state      <= EMPTY;
      in_ready_o <= 1'b1;
    end else begin
      case (state)
        EMPTY: if (in_fire) state <= BUSY;
        BUSY: begin
          if (in_fire && !out_fire) begin
            state      <= FULL;
            in_ready_o <= 1'b0;
          end else if (out_fire && !in_fire) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state      <= BUSY;
            in_ready_o <= 1'b1;
          end
        end
        default: begin
          state      <= EMPTY;
          in_ready_o <= 1'b1;
        end
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (!flush_i) begin
      case (state)
        EMPTY: main_load = in_fire;
        BUSY: begin
          main_load = in_fire & out_fire;
          skid_load = in_fire & ~out_fire;
        end
        FULL: begin
          main_load      = out_fire;
          main_from_skid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  pipe_payload_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (main_load),
    .clr_ctrl (flush_i),
    .clr_data (clr_data),
    .ctrl_d   (main_from_skid ? skid_ctrl : in_ctrl_i),
    .data_d   (main_from_skid ? skid_data : in_data_i),
    .ctrl_q   (main_ctrl),
    .data_q   (out_data_o)
  );

  pipe_payload_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (skid_load),
    .clr_ctrl (flush_i),
    .clr_data (clr_data),
    .ctrl_d   (in_ctrl_i),
    .data_d   (in_data_i),
    .ctrl_q   (skid_ctrl),
    .data_q   (skid_data)
  );

  // Bubbles present all-zero control so downstream write enables stay low.
  assign out_ctrl_o = out_valid_o ? main_ctrl : '0;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: two instances (data kept / data cleared on flush)
// driven identically and compared against a queue-based model every cycle.
module tb_pipe_skid_stage;

  localparam int CW = 12;
  localparam int DW = 165;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          in_ready0, out_valid0, in_ready1, out_valid1;
  logic [CW-1:0] out_ctrl0, out_ctrl1;
  logic [DW-1:0] out_data0, out_data1;
  logic [1:0]    count0, count1;

  entry_t        q[$];
  logic [DW-1:0] last0, last1;
  int            n_total = 0;
  int            n_pass  = 0;
  string         phase;

  always #5 clk = ~clk;

  pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA_ON_FLUSH(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(in_ready0), .in_ctrl_i(in_ctrl), .in_data_i(in_data),
    .out_valid_o(out_valid0), .out_ready_i(out_ready), .out_ctrl_o(out_ctrl0),
    .out_data_o(out_data0), .count_o(count0)
  );

  pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA_ON_FLUSH(1'b1)) dut_clr (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(in_ready1), .in_ctrl_i(in_ctrl), .in_data_i(in_data),
    .out_valid_o(out_valid1), .out_ready_i(out_ready), .out_ctrl_o(out_ctrl1),
    .out_data_o(out_data1), .count_o(count1)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s.%s: observed %0h expected %0h", phase, tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  // Expected outputs follow directly from the queue of held entries.
  task automatic check_all();
    logic          exp_valid;
    logic          exp_ready;
    logic [CW-1:0] exp_ctrl;
    logic [1:0]    exp_count;
    exp_valid = (q.size() > 0);
    exp_ready = (q.size() < 2);
    exp_ctrl  = exp_valid ? q[0].ctrl : '0;
    exp_count = 2'(q.size());
    check("valid",      256'(out_valid0), 256'(exp_valid));
    check("ready",      256'(in_ready0),  256'(exp_ready));
    check("count",      256'(count0),     256'(exp_count));
    check("ctrl",       256'(out_ctrl0),  256'(exp_ctrl));
    check("data",       256'(out_data0),  256'(last0));
    check("clr.valid",  256'(out_valid1), 256'(exp_valid));
    check("clr.ready",  256'(in_ready1),  256'(exp_ready));
    check("clr.count",  256'(count1),     256'(exp_count));
    check("clr.ctrl",   256'(out_ctrl1),  256'(exp_ctrl));
    check("clr.data",   256'(out_data1),  256'(last1));
  endtask

  // One clock: decide fires from the model, advance it at the edge, then compare.
  task automatic cycle();
    bit     in_fire;
    bit     out_fire;
    entry_t e;
    in_fire  = in_valid && (q.size() < 2);
    out_fire = out_ready && (q.size() > 0);
    e.ctrl   = in_ctrl;
    e.data   = in_data;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      last0 = '0;
      last1 = '0;
    end else if (flush) begin
      q.delete();
      last1 = '0;
    end else begin
      if (out_fire) void'(q.pop_front());
      if (in_fire)  q.push_back(e);
      if (q.size() > 0) begin
        last0 = q[0].data;
        last1 = q[0].data;
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    last0     = '0;
    last1     = '0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_ctrl   = 12'hABC;
    in_data   = rand_data();

    phase = "reset";
    cycle();
    cycle();
    rst_n = 1'b1;
    in_valid = 1'b0;
    cycle();

    phase = "stream";
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = DW'(i);
      in_ctrl = CW'(i * 3);
      cycle();
    end
    in_valid = 1'b0;
    cycle();

    phase = "stall";
    in_valid = 1'b1;
    in_data = DW'(1); cycle();
    in_data = DW'(2); cycle();
    out_ready = 1'b0;
    in_data = DW'(3); cycle();
    in_data = DW'(4); cycle();
    cycle();
    out_ready = 1'b1;
    cycle();
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();

    phase = "flush_full";
    in_valid = 1'b1;
    out_ready = 1'b0;
    in_ctrl = 12'h5A5;
    in_data = DW'(16'hA0A0); cycle();
    in_data = DW'(16'hB0B0); cycle();
    flush = 1'b1;
    in_data = DW'(16'hC0C0); cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    phase = "bubble";
    in_ctrl = 12'hFFF;
    in_data = rand_data();
    for (int i = 0; i < 4; i++) cycle();
    in_valid = 1'b1;
    out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) cycle();

    phase = "reset_flush";
    in_valid = 1'b1;
    out_ready = 1'b0;
    in_data = rand_data(); cycle();
    in_data = rand_data(); cycle();
    rst_n = 1'b0;
    flush = 1'b1;
    cycle();
    rst_n = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    cycle();

    phase = "random";
    for (int i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(99) != 0);
      flush     = ($urandom_range(19) == 0);
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      in_ctrl   = CW'($urandom);
      in_data   = rand_data();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised, flow-controlled pipeline register for the pipelined core, replacing fixed per-stage registers (decode→execute and onward) with a single generic stage. Carries a control payload and a data payload through a valid/ready handshake, absorbs downstream stalls in a two-entry skid buffer, and supports a synchronous flush for branch/jump squash. Control bits read as zero whenever the stage holds a bubble, so downstream register-write and memory-write enables cannot fire spuriously.

## Interface
- CTRL_W, 12, control payload width (reg_write, result_src, mem_write, jump, branch, alu_control, alu_src, imm_src); zeroed for bubbles.
- DATA_W, 165, data payload width (rd1, rd2, pc, rd, imm_ext, pc_plus4); never gated.
- CLEAR_DATA_ON_FLUSH, 0, when 1 the flush also zeroes stored data payloads.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush_i  in  1  squash every held and incoming entry this cycle.
- in_valid_i  in  1  upstream has a valid entry.
- in_ready_o  out  1  stage accepts an entry this cycle; registered.
- in_ctrl_i  in  CTRL_W  incoming control payload.
- in_data_i  in  DATA_W  incoming data payload.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  downstream consumes head this cycle.
- out_ctrl_o  out  CTRL_W  head control; forced 0 when out_valid_o=0.
- out_data_o  out  DATA_W  head data.
- count_o  out  2  entries held (0, 1, 2).

## Operation
- Fire rules: in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
- Storage: main entry (drives outputs) and skid entry, each ctrl+data.
- States: EMPTY (count 0), BUSY (main valid), FULL (main+skid valid).
- EMPTY: in_fire → BUSY, main ← input.
- BUSY: in_fire & out_fire → BUSY, main ← input; in_fire only → FULL, skid ← input; out_fire only → EMPTY; neither → hold.
- FULL: out_fire → BUSY, main ← skid; else hold. in_ready_o=0, so no in_fire.
- in_ready_o = (state != FULL), driven from a flop; no combinational path from out_ready_i.
- flush_i has priority over all fires: next state EMPTY, input dropped, stored ctrl fields cleared to 0; data cleared only if CLEAR_DATA_ON_FLUSH=1, else retained.
- Reset (rst_n=0 at edge) overrides flush: state EMPTY, all ctrl and data registers 0, in_ready_o=1 the following cycle.
- Entries are never reordered, duplicated or dropped except by flush/reset.

## Timing
- Reset values: out_valid_o=0, out_ctrl_o=0, out_data_o=0, count_o=0, in_ready_o=1.
- Latency: entry accepted at edge N appears on out_* after edge N (valid during cycle N+1).
- Throughput: one entry per cycle sustained while out_ready_i=1.
- Stall: out_ready_i dropping costs no entry; in_ready_o falls one cycle after the skid entry fills and rises the cycle after FULL drains to BUSY.
- Flush and in_valid_i in the same cycle: input discarded, EMPTY next cycle. Flush in FULL: both entries discarded.
- out_ctrl_o gating is combinational on out_valid_o; out_data_o is a direct register output.

## Structure
- Shared package pipe_pkg: enum skid_state_t {EMPTY, BUSY, FULL}; default constants PIPE_CTRL_W=12, PIPE_DATA_W=165.
- Sub-module pipe_payload_reg (CTRL_W, DATA_W; load enable, ctrl clear, data clear), instantiated twice (main, skid). Handshake FSM in the top.

## Test plan
- Reset: rst_n=0 two cycles with in_valid_i=1 → out_valid_o=0, out_ctrl_o=0, count_o=0, in_ready_o=1 on release.
- Streaming: in_valid_i=1 and out_ready_i=1 for 8 cycles, data 1..8 → out_data_o 1..8 on consecutive cycles, count_o stays 1.
- Stall absorption: stream 1..4, drop out_ready_i after entry 1 emitted → entries 2 and 3 held, count_o=2, in_ready_o=0; on out_ready_i=1, 2,3,4 emerge in order, none lost.
- Flush in FULL: count_o=2, assert flush_i with in_valid_i=1 → next cycle count_o=0, out_valid_o=0, out_ctrl_o=0, input never emerges.
- Bubble gating: in_ctrl_i=12'hFFF held while in_valid_i=0 → out_ctrl_o=0 throughout; CLEAR_DATA_ON_FLUSH=1 variant → out_data_o=0 after flush.
- Reset beats flush: rst_n=0 and flush_i=1 in FULL → all registers 0 including data regardless of CLEAR_DATA_ON_FLUSH.
